// File: rtl/cwe1262_uniform_reader.sv
// rtl/cwe1262_uniform_reader.sv - burst read responder that applies one lock uniformly to every bank entry
//
// Streams DEPTH x WIDTH register-bank entries out on a registered response
// channel. The single bank lock is checked for every beat, so no entry is
// exposed while the lock is high, whatever its index.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bank_flat  live bank contents, entry i at bits [i*WIDTH +: WIDTH]
//   lock       single lock covering all entries
//   req_valid  read request valid
//   req_ready  responder idle and able to accept a request
//   req_addr   start entry index
//   req_len    beats minus one
//   rsp_valid  response beat valid
//   rsp_ready  downstream accepts the beat
//   rsp_data   entry data, or zero when denied
//   rsp_addr   entry index of this beat
//   rsp_err    beat denied by lock
//   rsp_last   final beat of the burst
//   busy       burst in progress

module cwe1262_uniform_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DEPTH*WIDTH-1:0] bank_flat,
  input  logic                   lock,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AW-1:0]          req_addr,
  input  logic [AW-1:0]          req_len,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [AW-1:0]          rsp_addr,
  output logic                   rsp_err,
  output logic                   rsp_last,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t r_state;
  state_t w_state_next;

  logic [AW-1:0]    r_cur_addr;
  logic [AW-1:0]    r_remaining;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic [AW-1:0]    r_rsp_addr;
  logic             r_rsp_err;
  logic             r_rsp_last;

  logic [WIDTH-1:0] w_bank [DEPTH];
  logic [WIDTH-1:0] w_entry;
  logic             w_handshake;

  // Unflatten the bank so entry selection is a plain array index.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_unflatten
    assign w_bank[gi] = bank_flat[gi*WIDTH +: WIDTH];
  end

  assign w_entry     = w_bank[r_cur_addr];
  assign w_handshake = r_rsp_valid && rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_handshake) begin
          w_state_next = r_rsp_last ? ST_IDLE : ST_ISSUE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Burst bookkeeping and the registered response beat. The lock and the
  // entry are both captured in ISSUE only, so once a beat is presented,
  // neither lock changes nor bank writes can alter it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_addr  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_cur_addr  <= req_addr;
            r_remaining <= req_len;
          end
        end
        ST_ISSUE: begin
          r_rsp_valid <= 1'b1;
          r_rsp_addr  <= r_cur_addr;
          r_rsp_err   <= lock;
          r_rsp_data  <= lock ? '0 : w_entry;
          r_rsp_last  <= (r_remaining == '0);
        end
        ST_WAIT: begin
          if (w_handshake) begin
            r_rsp_valid <= 1'b0;
            if (!r_rsp_last) begin
              // DEPTH is a power of two, so the natural AW-bit wrap is modulo DEPTH.
              r_cur_addr  <= r_cur_addr + ONE;
              r_remaining <= r_remaining - ONE;
            end
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_err   = r_rsp_err;
  assign rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_cwe1262_uniform_reader.sv
// tb/tb_cwe1262_uniform_reader.sv - directed self-checking bench for cwe1262_uniform_reader

module tb_cwe1262_uniform_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] bank_flat;
  logic         lock;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_addr;
  logic [1:0]   req_len;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_addr;
  logic         rsp_err;
  logic         rsp_last;
  logic         busy;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] BANK_INIT = {32'h44, 32'h33, 32'h22, 32'h11};

  cwe1262_uniform_reader #(.WIDTH(32), .DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bank_flat (bank_flat),
    .lock      (lock),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stimulus only: wait (bounded) for req_ready, present one request for one cycle.
  task automatic do_req(input logic [1:0] a, input logic [1:0] l, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Stimulus only: wait (bounded) for the next valid beat and capture it.
  task automatic get_beat(output logic ok, output logic [31:0] d, output logic [1:0] a,
                          output logic e, output logic l);
    ok = 1'b0; d = '0; a = '0; e = 1'b0; l = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        d  = rsp_data;
        a  = rsp_addr;
        e  = rsp_err;
        l  = rsp_last;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    bank_flat = BANK_INIT;
    lock      = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (rsp_addr !== 2'd0) begin errors++; $display("FAIL reset_rsp_addr got=%0d exp=0", rsp_addr); end
    checks++; if ({rsp_err, rsp_last} !== 2'b00) begin errors++; $display("FAIL reset_err_last got=%b exp=00", {rsp_err, rsp_last}); end
  endtask

  task automatic test_single(input string tag);
    logic ok;
    do_req(2'd2, 2'd0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL %s_accept req_ready never seen", tag); end
    // One cycle after acceptance the beat is not yet valid.
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s_latency_early got=%0b exp=0", tag, rsp_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got=%0b exp=1", tag, busy); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL %s_latency got=%0b exp=1", tag, rsp_valid); end
    checks++; if (rsp_data !== 32'h33) begin errors++; $display("FAIL %s_data got=%h exp=33", tag, rsp_data); end
    checks++; if (rsp_addr !== 2'd2) begin errors++; $display("FAIL %s_addr got=%0d exp=2", tag, rsp_addr); end
    checks++; if ({rsp_err, rsp_last} !== 2'b01) begin errors++; $display("FAIL %s_err_last got=%b exp=01", tag, {rsp_err, rsp_last}); end
    @(negedge clk);
    checks++; if ({rsp_valid, busy, req_ready} !== 3'b001) begin errors++; $display("FAIL %s_done valid/busy/ready got=%b exp=001", tag, {rsp_valid, busy, req_ready}); end
  endtask

  task automatic test_wrap;
    logic ok, e, l;
    logic [31:0] d;
    logic [1:0]  a;
    logic [31:0] exp_d [4] = '{32'h44, 32'h11, 32'h22, 32'h33};
    logic [1:0]  exp_a [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    do_req(2'd3, 2'd3, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_accept req_ready never seen"); end
    for (int b = 0; b < 4; b++) begin
      get_beat(ok, d, a, e, l);
      checks++; if (!ok || d !== exp_d[b]) begin errors++; $display("FAIL wrap_data beat=%0d got=%h exp=%h valid_seen=%0b", b, d, exp_d[b], ok); end
      checks++; if (a !== exp_a[b]) begin errors++; $display("FAIL wrap_addr beat=%0d got=%0d exp=%0d", b, a, exp_a[b]); end
      checks++; if ({e, l} !== {1'b0, (b == 3)}) begin errors++; $display("FAIL wrap_err_last beat=%0d got=%b exp=%b", b, {e, l}, {1'b0, (b == 3)}); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_busy_drop got=%0b exp=0", busy); end
  endtask

  task automatic test_locked;
    logic ok, e, l;
    logic [31:0] d;
    logic [1:0]  a, ea;
    lock = 1'b1;
    for (int s = 0; s < 4; s++) begin
      do_req(2'(s), 2'd1, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL locked_accept start=%0d req_ready never seen", s); end
      for (int b = 0; b < 2; b++) begin
        ea = 2'(s + b);
        get_beat(ok, d, a, e, l);
        checks++; if (!ok || d !== 32'h0) begin errors++; $display("FAIL locked_data start=%0d beat=%0d got=%h exp=0 valid_seen=%0b", s, b, d, ok); end
        checks++; if (a !== ea) begin errors++; $display("FAIL locked_addr start=%0d beat=%0d got=%0d exp=%0d", s, b, a, ea); end
        checks++; if ({e, l} !== {1'b1, (b == 1)}) begin errors++; $display("FAIL locked_err_last start=%0d beat=%0d got=%b exp=%b", s, b, {e, l}, {1'b1, (b == 1)}); end
      end
      @(negedge clk);
    end
    lock = 1'b0;
  endtask

  task automatic test_mid_lock;
    logic ok, e, l;
    logic [31:0] d;
    logic [1:0]  a;
    logic [31:0] exp_d [4] = '{32'h11, 32'h22, 32'h0, 32'h0};
    do_req(2'd0, 2'd3, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL midlock_accept req_ready never seen"); end
    for (int b = 0; b < 4; b++) begin
      get_beat(ok, d, a, e, l);
      checks++; if (!ok || d !== exp_d[b]) begin errors++; $display("FAIL midlock_data beat=%0d got=%h exp=%h valid_seen=%0b", b, d, exp_d[b], ok); end
      checks++; if ({a, e, l} !== {2'(b), (b >= 2), (b == 3)}) begin errors++; $display("FAIL midlock_addr_err_last beat=%0d got=%b exp=%b", b, {a, e, l}, {2'(b), (b >= 2), (b == 3)}); end
      if (b == 1) begin
        @(posedge clk);
        #1 lock = 1'b1;
      end
    end
    @(negedge clk);
    lock = 1'b0;
  endtask

  task automatic test_backpressure;
    logic ok, e, l;
    logic [31:0] d;
    logic [1:0]  a;
    rsp_ready = 1'b0;
    do_req(2'd1, 2'd1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_accept req_ready never seen"); end
    get_beat(ok, d, a, e, l);
    checks++; if (!ok || {d, a, e, l} !== {32'h22, 2'd1, 1'b0, 1'b0}) begin errors++; $display("FAIL bp_beat1 got=%h/%0d/%b/%b exp=22/1/0/0", d, a, e, l); end
    for (int c = 0; c < 5; c++) begin
      bank_flat[63:32] = (c % 2 == 0) ? 32'hAAAA_5555 : 32'h22;
      lock      = (c % 2 == 0);
      req_valid = (c == 2);
      req_addr  = 2'd3;
      req_len   = 2'd0;
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_data, rsp_addr, rsp_err, rsp_last} !== {1'b1, 32'h22, 2'd1, 1'b0, 1'b0}) begin
        errors++; $display("FAIL bp_hold cycle=%0d got=%b/%h/%0d/%b/%b exp=1/22/1/0/0", c, rsp_valid, rsp_data, rsp_addr, rsp_err, rsp_last);
      end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready cycle=%0d got=%0b exp=0", c, req_ready); end
    end
    req_valid = 1'b0;
    lock      = 1'b0;
    bank_flat = BANK_INIT;
    rsp_ready = 1'b1;
    get_beat(ok, d, a, e, l);
    checks++; if (!ok || {d, a, e, l} !== {32'h33, 2'd2, 1'b0, 1'b1}) begin errors++; $display("FAIL bp_beat2 got=%h/%0d/%b/%b exp=33/2/0/1", d, a, e, l); end
    repeat (3) @(negedge clk);
    // The request pulsed while busy must not have been latched.
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_ignored_req valid/busy got=%b exp=00", {rsp_valid, busy}); end
  endtask

  task automatic test_reset_mid;
    logic ok, e, l;
    logic [31:0] d;
    logic [1:0]  a;
    do_req(2'd0, 2'd3, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_accept req_ready never seen"); end
    get_beat(ok, d, a, e, l);
    get_beat(ok, d, a, e, l);
    checks++; if (!ok || d !== 32'h22) begin errors++; $display("FAIL rstmid_beat2 got=%h exp=22 valid_seen=%0b", d, ok); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({rsp_valid, busy, rsp_last} !== 3'b000) begin errors++; $display("FAIL rstmid_async valid/busy/last got=%b exp=000", {rsp_valid, busy, rsp_last}); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", rsp_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_req_ready got=%0b exp=1", req_ready); end
    test_single("after_reset");
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_wrap();
    test_locked();
    test_mid_lock();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
